count_wrap_monitor: RTL

Downstream consumer of the 4-bit modulo counter stage: the block samples the counter value every clock and emits a one-cycle pulse on each wrap from the terminal value back to 0. It keeps a two-digit BCD tally of wraps and flags any illegal step in the count sequence (skip, out-of-range value, backward move). The wrap pulse and tally drive the next timing stage and the status display.

---
 rtl/count_wrap_monitor.sv | 118 +++++++++++
 1 files changed

// File: rtl/count_wrap_monitor.sv
// Watches an upstream modulo counter: pulses once per MAX_VAL->0 wrap, keeps a BCD wrap tally,
// latches the first illegal step. Registered outputs, one cycle after the sampling edge; no backpressure.
module count_wrap_monitor #(
  parameter int MAX_VAL = 10,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count_in,
  input  logic             clear,
  output logic             wrap_pulse,
  output logic [7:0]       tally_bcd,
  output logic             tally_ovf,
  output logic             step_err,
  output logic [CNT_W-1:0] err_value,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_TRACK = 2'b01,
    S_ERROR = 2'b10
  } state_t;

  localparam logic [CNT_W:0] MAX_EXT = (CNT_W+1)'(MAX_VAL);
  localparam logic [CNT_W:0] ONE_EXT = (CNT_W+1)'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_prev;
  logic             r_pulse;
  logic [7:0]       r_tally;
  logic             r_ovf;
  logic             r_err;
  logic [CNT_W-1:0] r_err_value;

  logic       w_hold;
  logic       w_step;
  logic       w_wrap;
  logic [7:0] w_tally_nxt;
  logic       w_tally_roll;

  assign w_hold = (count_in == r_prev);
  assign w_step = ({1'b0, r_prev} < MAX_EXT) && ({1'b0, count_in} == ({1'b0, r_prev} + ONE_EXT));
  assign w_wrap = ({1'b0, r_prev} == MAX_EXT) && (count_in == '0);

  // Decimal increment of the two-digit tally; 99 rolls to 00 and raises the overflow flag.
  always_comb begin
    w_tally_nxt  = r_tally;
    w_tally_roll = 1'b0;
    if (r_tally[3:0] == 4'd9) begin
      w_tally_nxt[3:0] = 4'd0;
      if (r_tally[7:4] == 4'd9) begin
        w_tally_nxt[7:4] = 4'd0;
        w_tally_roll     = 1'b1;
      end else begin
        w_tally_nxt[7:4] = r_tally[7:4] + 4'd1;
      end
    end else begin
      w_tally_nxt[3:0] = r_tally[3:0] + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      r_pulse     <= 1'b0;
      r_tally     <= 8'h00;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_err_value <= '0;
    end else if (clear) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      r_pulse     <= 1'b0;
      r_tally     <= 8'h00;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_err_value <= '0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_prev  <= count_in;
          r_state <= S_TRACK;
        end
        S_TRACK: begin
          if (w_hold) begin
            r_prev <= r_prev;
          end else if (w_step) begin
            r_prev <= count_in;
          end else if (w_wrap) begin
            r_prev  <= '0;
            r_pulse <= 1'b1;
            r_tally <= w_tally_nxt;
            if (w_tally_roll) r_ovf <= 1'b1;
          end else begin
            r_err       <= 1'b1;
            r_err_value <= count_in;
            r_state     <= S_ERROR;
          end
        end
        default: r_state <= S_ERROR;
      endcase
    end
  end

  assign wrap_pulse = r_pulse;
  assign tally_bcd  = r_tally;
  assign tally_ovf  = r_ovf;
  assign step_err   = r_err;
  assign err_value  = r_err_value;
  assign state      = r_state;

  // A legal counter can never wrap on two consecutive samples.
  a_no_double_pulse: assert property (@(posedge clk) disable iff (!rst) wrap_pulse |=> !wrap_pulse);

endmodule
